// File: rtl/fifo2axis.sv
// fifo2axis: gathers words from a write-strobe producer into a BURST_LEN-word packet
// buffer, then sends the packet as an AXI4-Stream master burst with tlast on the final beat.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   din           producer data word
//   wr            write strobe; word taken on an edge where wr && in_ready
//   flush         close a partial packet early (ignored when the buffer is empty)
//   in_ready      buffer can accept a word (FILL state)
//   m_axis_tdata  stream data (0 when not streaming)
//   m_axis_tvalid stream valid
//   m_axis_tready consumer ready
//   m_axis_tlast  final beat of the packet
//   done          one-cycle pulse after a packet completes
//   pkt_count     completed-packet counter, wraps at 16 bits
module fifo2axis #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr,
  input  logic                  flush,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  done,
  output logic [15:0]           pkt_count
);

  localparam int unsigned IdxW  = $clog2(BURST_LEN) + 1;
  localparam int unsigned AddrW = $clog2(BURST_LEN);

  typedef enum logic [1:0] {
    StFill,
    StStream,
    StDone
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [DATA_WIDTH-1:0] r_buf [BURST_LEN];
  logic [IdxW-1:0]       r_count;
  logic [IdxW-1:0]       w_count_d;
  logic [IdxW-1:0]       r_rd_idx;
  logic [IdxW-1:0]       w_rd_idx_d;
  logic [IdxW-1:0]       r_len;
  logic [IdxW-1:0]       w_len_d;
  logic [15:0]           r_pkt_count;
  logic [15:0]           w_pkt_count_d;

  logic                  w_wr_acc;
  logic                  w_last;
  logic [IdxW-1:0]       w_count_inc;

  assign w_wr_acc    = wr && (r_state == StFill);
  assign w_count_inc = r_count + IdxW'(1);
  assign w_last      = (r_rd_idx == (r_len - IdxW'(1)));

  always_comb begin
    w_state_d     = r_state;
    w_count_d     = r_count;
    w_rd_idx_d    = r_rd_idx;
    w_len_d       = r_len;
    w_pkt_count_d = r_pkt_count;
    case (r_state)
      StFill: begin
        if (wr) begin
          w_count_d = w_count_inc;
          // A flush on the same edge as a write closes the packet including that word.
          if ((w_count_inc == IdxW'(BURST_LEN)) || flush) begin
            w_state_d = StStream;
            w_len_d   = w_count_inc;
          end
        end else if (flush && (r_count != '0)) begin
          w_state_d = StStream;
          w_len_d   = r_count;
        end
      end
      StStream: begin
        if (m_axis_tready) begin
          if (w_last) begin
            w_state_d     = StDone;
            w_count_d     = '0;
            w_rd_idx_d    = '0;
            w_pkt_count_d = r_pkt_count + 16'd1;
          end else begin
            w_rd_idx_d = r_rd_idx + IdxW'(1);
          end
        end
      end
      StDone: begin
        w_state_d = StFill;
      end
      default: begin
        w_state_d = StFill;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StFill;
      r_count     <= '0;
      r_rd_idx    <= '0;
      r_len       <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_count     <= w_count_d;
      r_rd_idx    <= w_rd_idx_d;
      r_len       <= w_len_d;
      r_pkt_count <= w_pkt_count_d;
    end
  end

  // Packet storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_buf[r_count[AddrW-1:0]] <= din;
    end
  end

  // Outputs decode registered state only; tready never reaches them combinationally.
  assign in_ready      = (r_state == StFill);
  assign m_axis_tvalid = (r_state == StStream);
  assign m_axis_tlast  = (r_state == StStream) && w_last;
  assign m_axis_tdata  = (r_state == StStream) ? r_buf[r_rd_idx[AddrW-1:0]] : '0;
  assign done          = (r_state == StDone);
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_fifo2axis.sv
// tb_fifo2axis: directed, table-driven bench for fifo2axis (DATA_WIDTH=32, BURST_LEN=4).
// Each table row is one clock cycle: outputs expected in that cycle plus inputs driven in it.
module tb_fifo2axis;

  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr;
  logic          flush;
  logic          in_ready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          done;
  logic [15:0]   pkt_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo2axis #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr           (wr),
    .flush        (flush),
    .in_ready     (in_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .done         (done),
    .pkt_count    (pkt_count)
  );

  typedef struct {
    logic        wr;
    logic        flush;
    logic [31:0] din;
    logic        tready;
    logic        e_ready;
    logic        e_valid;
    logic        e_last;
    logic        e_done;
    logic [31:0] e_data;
    logic [15:0] e_pkt;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic w, input logic f, input logic [31:0] d, input logic tr,
                            input logic er, input logic ev, input logic el, input logic ed,
                            input logic [31:0] edata, input logic [15:0] epkt);
    vec_t r;
    r.wr = w; r.flush = f; r.din = d; r.tready = tr;
    r.e_ready = er; r.e_valid = ev; r.e_last = el; r.e_done = ed;
    r.e_data = edata; r.e_pkt = epkt;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic er, input logic ev, input logic el,
                          input logic ed, input logic [31:0] edata, input logic [15:0] epkt);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(er));
    chk({tag, " tvalid"}, 32'(m_axis_tvalid), 32'(ev));
    chk({tag, " tlast"}, 32'(m_axis_tlast), 32'(el));
    chk({tag, " done"}, 32'(done), 32'(ed));
    chk({tag, " tdata"}, m_axis_tdata, edata);
    chk({tag, " pkt_count"}, 32'(pkt_count), 32'(epkt));
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic f, input logic [31:0] d, input logic tr);
    wr = w; flush = f; din = d; m_axis_tready = tr;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Full packet, tready tied high.
    v(1, 0, 32'h11, 1, 1, 0, 0, 0, 32'h0, 16'd0);
    v(1, 0, 32'h22, 1, 1, 0, 0, 0, 32'h0, 16'd0);
    v(1, 0, 32'h33, 1, 1, 0, 0, 0, 32'h0, 16'd0);
    v(1, 0, 32'h44, 1, 1, 0, 0, 0, 32'h0, 16'd0);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h11, 16'd0);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h22, 16'd0);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h33, 16'd0);
    v(0, 0, 32'h0, 1, 0, 1, 1, 0, 32'h44, 16'd0);
    v(0, 0, 32'h0, 1, 0, 0, 0, 1, 32'h0, 16'd1);
    v(0, 0, 32'h0, 1, 1, 0, 0, 0, 32'h0, 16'd1);
    // Backpressure: tready low for 3 cycles on beat 1.
    v(1, 0, 32'h11, 1, 1, 0, 0, 0, 32'h0, 16'd1);
    v(1, 0, 32'h22, 1, 1, 0, 0, 0, 32'h0, 16'd1);
    v(1, 0, 32'h33, 1, 1, 0, 0, 0, 32'h0, 16'd1);
    v(1, 0, 32'h44, 1, 1, 0, 0, 0, 32'h0, 16'd1);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h11, 16'd1);
    v(0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h22, 16'd1);
    v(0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h22, 16'd1);
    v(0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h22, 16'd1);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h22, 16'd1);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h33, 16'd1);
    v(0, 0, 32'h0, 1, 0, 1, 1, 0, 32'h44, 16'd1);
    v(0, 0, 32'h0, 1, 0, 0, 0, 1, 32'h0, 16'd2);
    // Flush alone after two words; writes/flushes during STREAM and DONE must be dropped.
    v(1, 0, 32'hA1, 1, 1, 0, 0, 0, 32'h0, 16'd2);
    v(1, 0, 32'hA2, 1, 1, 0, 0, 0, 32'h0, 16'd2);
    v(0, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0, 16'd2);
    v(1, 1, 32'hEE, 1, 0, 1, 0, 0, 32'hA1, 16'd2);
    v(1, 1, 32'hEE, 1, 0, 1, 1, 0, 32'hA2, 16'd2);
    v(1, 1, 32'hEF, 1, 0, 0, 0, 1, 32'h0, 16'd3);
    // Write and flush on the same edge after two words.
    v(1, 0, 32'hB1, 1, 1, 0, 0, 0, 32'h0, 16'd3);
    v(1, 0, 32'hB2, 1, 1, 0, 0, 0, 32'h0, 16'd3);
    v(1, 1, 32'hB3, 1, 1, 0, 0, 0, 32'h0, 16'd3);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'hB1, 16'd3);
    v(0, 0, 32'h0, 1, 0, 1, 0, 0, 32'hB2, 16'd3);
    v(0, 0, 32'h0, 1, 0, 1, 1, 0, 32'hB3, 16'd3);
    v(0, 0, 32'h0, 1, 0, 0, 0, 1, 32'h0, 16'd4);
    // Flush on an empty buffer is ignored.
    v(0, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0, 16'd4);
    v(0, 1, 32'h0, 1, 1, 0, 0, 0, 32'h0, 16'd4);
    v(0, 0, 32'h0, 1, 1, 0, 0, 0, 32'h0, 16'd4);

    // Reset: two edges with rst high, outputs defined after the first.
    rst = 1'b1;
    drive(0, 0, 32'h0, 1);
    step();
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].flush, vecs[i].din, vecs[i].tready);
      chk_outs($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_last,
               vecs[i].e_done, vecs[i].e_data, vecs[i].e_pkt);
      step();
    end

    // Reset mid-stream after beat 1 handshakes.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'hC1 + 32'(i), 1);
      step();
    end
    drive(0, 0, 32'h0, 1);
    chk_outs("mid beat0", 1'b0, 1'b1, 1'b0, 1'b0, 32'hC1, 16'd4);
    step();
    chk_outs("mid beat1", 1'b0, 1'b1, 1'b0, 1'b0, 32'hC2, 16'd4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_outs("mid after rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'hD1 + 32'(i), 1);
      step();
    end
    drive(0, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      chk_outs($sformatf("post rst beat%0d", i), 1'b0, 1'b1, (i == 3), 1'b0,
               32'hD1 + 32'(i), 16'd0);
      step();
    end
    chk_outs("post rst done", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 16'd1);
    step();
    chk_outs("post rst fill", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'd1);

    // Counter wrap: preload the counter to FFFE across one idle edge, then two packets.
    force dut.r_pkt_count = 16'hFFFE;
    step();
    release dut.r_pkt_count;
    step();
    chk_outs("wrap preload", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'hFFFE);
    for (int p = 0; p < 2; p++) begin
      drive(1, 1, 32'h5A + 32'(p), 1);
      step();
      drive(0, 0, 32'h0, 1);
      chk_outs($sformatf("wrap%0d beat", p), 1'b0, 1'b1, 1'b1, 1'b0, 32'h5A + 32'(p),
               16'hFFFE + 16'(p));
      step();
      chk_outs($sformatf("wrap%0d done", p), 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,
               16'hFFFF + 16'(p));
      step();
    end
    chk_outs("wrap fill", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
